led_seq_ctrl: RTL and testbench
===============================

Name: led_seq_ctrl

Overview:
Sequencer that drives a bank of LEDs through a programmable table of on/off patterns, each held for a programmable number of time ticks. Generalises the single free-running blinker into a controlled resource: software or bringup logic loads the table, then issues start/stop and observes busy/done. Sits between board-level control logic and the LED pins.

Parameters:
NUM_LEDS, 4, number of LED outputs / pattern width
STEPS, 8, table depth (power of two)
DUR_W, 8, width of per-step duration field, in ticks
TICK_DIV, 50000, clk cycles per tick (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_we  in  1  table write strobe
cfg_addr  in  log2(STEPS)  table entry index
cfg_pattern  in  NUM_LEDS  LED pattern for entry
cfg_dur  in  DUR_W  hold time in ticks; 0 = end-of-sequence marker
start  in  1  begin sequence at entry 0 (level sampled each cycle)
stop  in  1  abort sequence
loop  in  1  1 = restart at entry 0 after last step
busy  out  1  high while in RUN
done  out  1  one-cycle pulse at normal sequence end
step_idx  out  log2(STEPS)  current entry index
led  out  NUM_LEDS  LED drive

Behaviour:
- Reset: state IDLE, led=0, busy=0, done=0, step_idx=0, prescaler=0, tick counter=0; table entries reset to pattern 0, dur 0.
- Table: cfg_we writes entry cfg_addr on the clock edge; allowed in any state. Step entry reads table contents as of that cycle (before a same-cycle write).
- States: IDLE, RUN.
- IDLE: led=0, busy=0. start=1 and entry0.dur!=0 -> next cycle RUN, step_idx=0, led=entry0.pattern, counters cleared. start=1 with entry0.dur==0 -> stay IDLE, done pulses next cycle.
- RUN: prescaler counts 0..TICK_DIV-1; wrap = tick. Tick counter increments per tick; step ends on the tick that makes it equal to the latched dur. Each step therefore shows its pattern for exactly dur*TICK_DIV cycles.
- Step end: next = step_idx+1. If step_idx==STEPS-1 or entry[next].dur==0 -> end-of-sequence; otherwise load entry[next] next cycle, counters cleared.
- End-of-sequence: loop=1 and entry0.dur!=0 -> reload entry0, stay RUN, no done. Else -> IDLE next cycle, led=0, step_idx=0, done=1 for one cycle.
- stop=1 in RUN: next cycle IDLE, led=0, step_idx=0, no done. stop has priority over start and over step end in the same cycle. start in RUN ignored.
- busy == (state==RUN). Duration latched at step entry; later writes to the active entry apply only on its next entry.
- rst mid-RUN: all state per reset next cycle; done not asserted.

Optional Feature:
Macro LED_SEQ_PWM_EN. Defined: adds input cfg_bright[3:0] and a free-running 4-bit PWM counter (reset 0, counts every clk); led = pattern & {NUM_LEDS{pwm_cnt < cfg_bright}}; cfg_bright=0 -> LEDs off, 15 -> on 15/16 of cycles. Not defined: no port, led = pattern directly.

Test Plan:
- TICK_DIV=4. Table {0:4'b0001,dur 2}, {1:4'b0010,dur 1}, {2:dur 0}; start, loop=0 -> led=0001 for 8 clk, 0010 for 4 clk, then led=0, done high exactly 1 cycle, busy low.
- Same table, loop=1 -> pattern repeats 0001(8)/0010(4) for 3 iterations, done never asserts; stop -> led=0 and busy=0 next cycle.
- All 8 entries dur=1, patterns 1..8, loop=0 -> step_idx steps 0..7 every 4 clk, wrap to IDLE after entry 7 with done pulse.
- entry0.dur=0, start -> stays IDLE, busy=0, done pulses once.
- During entry0 run, write entry1 pattern 4'b1111 -> entry1 shows 1111; rewrite active entry0 dur -> current step keeps latched dur.
- Assert rst mid-RUN, simultaneous start+stop in IDLE -> all outputs reset values; start+stop gives no RUN entry.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: plays a programmable table of (pattern, duration) steps.
// Optional LED_SEQ_PWM_EN adds a 4-bit brightness input and a PWM gate on the LEDs.
module led_seq_ctrl #(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned STEPS    = 8,
    parameter int unsigned DUR_W    = 8,
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [$clog2(STEPS)-1:0]     cfg_addr,
    input  logic [NUM_LEDS-1:0]          cfg_pattern,
    input  logic [DUR_W-1:0]             cfg_dur,
`ifdef LED_SEQ_PWM_EN
    input  logic [3:0]                   cfg_bright,
`endif
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(STEPS)-1:0]     step_idx,
    output logic [NUM_LEDS-1:0]          led
);

    localparam int unsigned AW = $clog2(STEPS);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] LAST_STEP = AW'(STEPS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [NUM_LEDS-1:0]   r_pat_tab [STEPS];
    logic [DUR_W-1:0]      r_dur_tab [STEPS];
    logic [NUM_LEDS-1:0]   r_led;
    logic [DUR_W-1:0]      r_dur_lat;
    logic [PW-1:0]         r_presc;
    logic [DUR_W-1:0]      r_tick;
    logic [AW-1:0]         r_step;
    logic                  r_done;

    logic [AW-1:0]         w_next;
    logic [DUR_W-1:0]      w_tick_nxt;
    logic                  w_tick;
    logic                  w_step_end;
    logic                  w_last;
    logic                  w_can_loop;

    assign w_next     = r_step + AW'(1);
    assign w_tick_nxt = r_tick + DUR_W'(1);
    assign w_tick     = (r_presc == PRESC_MAX);
    assign w_step_end = w_tick && (w_tick_nxt == r_dur_lat);
    assign w_last     = (r_step == LAST_STEP) || (r_dur_tab[w_next] == '0);
    assign w_can_loop = loop && (r_dur_tab[0] != '0);

    // Pattern/duration table; reads elsewhere see the pre-write contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(STEPS); i++) begin
                r_pat_tab[i] <= '0;
                r_dur_tab[i] <= '0;
            end
        end else if (cfg_we) begin
            r_pat_tab[cfg_addr] <= cfg_pattern;
            r_dur_tab[cfg_addr] <= cfg_dur;
        end
    end

    // Sequencer FSM; stop outranks start and step end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_led     <= '0;
            r_dur_lat <= '0;
            r_presc   <= '0;
            r_tick    <= '0;
            r_step    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        if (r_dur_tab[0] != '0) begin
                            r_state   <= S_RUN;
                            r_step    <= '0;
                            r_led     <= r_pat_tab[0];
                            r_dur_lat <= r_dur_tab[0];
                            r_presc   <= '0;
                            r_tick    <= '0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_led   <= '0;
                        r_step  <= '0;
                    end else if (w_step_end) begin
                        r_presc <= '0;
                        r_tick  <= '0;
                        if (!w_last) begin
                            r_step    <= w_next;
                            r_led     <= r_pat_tab[w_next];
                            r_dur_lat <= r_dur_tab[w_next];
                        end else if (w_can_loop) begin
                            r_step    <= '0;
                            r_led     <= r_pat_tab[0];
                            r_dur_lat <= r_dur_tab[0];
                        end else begin
                            r_state <= S_IDLE;
                            r_led   <= '0;
                            r_step  <= '0;
                            r_done  <= 1'b1;
                        end
                    end else if (w_tick) begin
                        r_presc <= '0;
                        r_tick  <= w_tick_nxt;
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = r_done;
    assign step_idx = r_step;

`ifdef LED_SEQ_PWM_EN
    logic [3:0] r_pwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 4'(1);
        end
    end

    assign led = r_led & {NUM_LEDS{r_pwm < cfg_bright}};
`else
    assign led = r_led;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: expected per-cycle outputs are queued with the
// stimulus and compared one per clock, sampled 1 time unit after the rising edge.
module tb_led_seq_ctrl;

    localparam int unsigned NUM_LEDS = 4;
    localparam int unsigned STEPS    = 8;
    localparam int unsigned DUR_W    = 8;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned AW       = $clog2(STEPS);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cfg_we = 1'b0;
    logic [AW-1:0]        cfg_addr = '0;
    logic [NUM_LEDS-1:0]  cfg_pattern = '0;
    logic [DUR_W-1:0]     cfg_dur = '0;
    logic                 start = 1'b0;
    logic                 stop = 1'b0;
    logic                 loop = 1'b0;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        step_idx;
    logic [NUM_LEDS-1:0]  led;
`ifdef LED_SEQ_PWM_EN
    logic [3:0]           cfg_bright = 4'hF;
`endif

    typedef struct {
        logic [NUM_LEDS-1:0] led;
        logic                busy;
        logic                done;
        logic [AW-1:0]       step;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    led_seq_ctrl #(
        .NUM_LEDS (NUM_LEDS),
        .STEPS    (STEPS),
        .DUR_W    (DUR_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_pattern (cfg_pattern),
        .cfg_dur     (cfg_dur),
`ifdef LED_SEQ_PWM_EN
        .cfg_bright  (cfg_bright),
`endif
        .start       (start),
        .stop        (stop),
        .loop        (loop),
        .busy        (busy),
        .done        (done),
        .step_idx    (step_idx),
        .led         (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic push(input logic [NUM_LEDS-1:0] l, input logic b, input logic d,
                        input logic [AW-1:0] s, input int n);
        exp_t e;
        e.led  = l;
        e.busy = b;
        e.done = d;
        e.step = s;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // Advance one clock, release one-shot controls, compare one queued expectation.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        start  = 1'b0;
        stop   = 1'b0;
        cfg_we = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("led",      32'(led),      32'(e.led));
            chk("busy",     32'(busy),     32'(e.busy));
            chk("done",     32'(done),     32'(e.done));
            chk("step_idx", 32'(step_idx), 32'(e.step));
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) tick();
    endtask

    task automatic wr(input int a, input logic [NUM_LEDS-1:0] p, input logic [DUR_W-1:0] d);
        cfg_we      = 1'b1;
        cfg_addr    = AW'(a);
        cfg_pattern = p;
        cfg_dur     = d;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        push(4'b0000, 1'b0, 1'b0, 0, 2);
        tick();
        rst = 1'b0;
        tick();

        // Basic one-shot sequence
        wr(0, 4'b0001, 2);
        wr(1, 4'b0010, 1);
        wr(2, 4'b0000, 0);
        start = 1'b1;
        push(4'b0001, 1'b1, 1'b0, 0, 8);
        push(4'b0010, 1'b1, 1'b0, 1, 4);
        push(4'b0000, 1'b0, 1'b1, 0, 1);
        push(4'b0000, 1'b0, 1'b0, 0, 3);
        drain();

        // Looping, then stop mid-step
        loop  = 1'b1;
        start = 1'b1;
        for (int it = 0; it < 3; it++) begin
            push(4'b0001, 1'b1, 1'b0, 0, 8);
            push(4'b0010, 1'b1, 1'b0, 1, 4);
        end
        push(4'b0001, 1'b1, 1'b0, 0, 2);
        drain();
        stop = 1'b1;
        push(4'b0000, 1'b0, 1'b0, 0, 3);
        drain();
        loop = 1'b0;

        // Full table walk, all steps of one tick
        for (int i = 0; i < int'(STEPS); i++) wr(i, NUM_LEDS'(i + 1), 1);
        start = 1'b1;
        for (int i = 0; i < int'(STEPS); i++) push(NUM_LEDS'(i + 1), 1'b1, 1'b0, AW'(i), 4);
        push(4'b0000, 1'b0, 1'b1, 0, 1);
        push(4'b0000, 1'b0, 1'b0, 0, 2);
        drain();

        // Empty sequence: done pulse only
        wr(0, 4'b0101, 0);
        start = 1'b1;
        push(4'b0000, 1'b0, 1'b1, 0, 1);
        push(4'b0000, 1'b0, 1'b0, 0, 2);
        drain();

        // Table writes while running
        wr(0, 4'b0001, 2);
        wr(1, 4'b0010, 1);
        wr(2, 4'b0000, 0);
        start = 1'b1;
        push(4'b0001, 1'b1, 1'b0, 0, 8);
        push(4'b1111, 1'b1, 1'b0, 1, 4);
        push(4'b0000, 1'b0, 1'b1, 0, 1);
        push(4'b0000, 1'b0, 1'b0, 0, 2);
        tick();
        wr(1, 4'b1111, 1);
        wr(0, 4'b0001, 1);
        drain();
        start = 1'b1;
        push(4'b0001, 1'b1, 1'b0, 0, 4);
        push(4'b1111, 1'b1, 1'b0, 1, 4);
        push(4'b0000, 1'b0, 1'b1, 0, 1);
        push(4'b0000, 1'b0, 1'b0, 0, 1);
        drain();

        // Reset in the middle of a run clears state and table
        start = 1'b1;
        push(4'b0001, 1'b1, 1'b0, 0, 3);
        drain();
        rst = 1'b1;
        push(4'b0000, 1'b0, 1'b0, 0, 1);
        tick();
        rst = 1'b0;
        push(4'b0000, 1'b0, 1'b0, 0, 2);
        drain();
        start = 1'b1;
        push(4'b0000, 1'b0, 1'b1, 0, 1);
        push(4'b0000, 1'b0, 1'b0, 0, 1);
        drain();

        // Simultaneous start and stop in IDLE does nothing
        wr(0, 4'b0001, 2);
        start = 1'b1;
        stop  = 1'b1;
        push(4'b0000, 1'b0, 1'b0, 0, 3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
